amp_power_sequencer: RTL and testbench
======================================

AMP_POWER_SEQUENCER -- requirements
Module: amp_power_sequencer

Interface
REQ-001 Parameter T_SETTLE, default 1000, clk cycles between amp_en rise and the configuration request.
REQ-002 Parameter T_CFG_TO, default 4000, clk cycles allowed for cfg_done after send_cfg.
REQ-003 Parameter T_MUTE, default 500, clk cycles of muted dwell before unmute and before power-down.
REQ-004 Parameter T_OFF, default 2000, clk cycles the amp is held off before a retry.
REQ-005 Parameter MAX_RETRY, default 3, maximum automatic power-cycle retries.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 resetb  input  1  synchronous, active-low reset.
REQ-008 enable  input  1  level request to run the amplifier.
REQ-009 cfg_done  input  1  one-cycle pulse from the I2C config master; the boot program has been sent.
REQ-010 amp_fault_n  input  1  asynchronous active-low fault pin from the amp.
REQ-011 amp_en  output  1  amp enable/power pin.
REQ-012 send_cfg  output  1  one-cycle pulse that starts the I2C config master.
REQ-013 amp_mute_n  output  1  active-low mute to the amp; 1 = playing.
REQ-014 fault  output  1  high while in FAULT.
REQ-015 seq_state  output  3  current state encoding, per REQ-017.

Function
REQ-016 amp_fault_n SHALL pass through a 2-flop synchronizer; fault_sync is its inverted output, so the FSM sees a fault edge 2 cycles late.
REQ-017 FSM states: OFF=0, POWER_UP=1, CONFIG=2, WAIT_CFG=3, UNMUTE_DLY=4, RUN=5, FAULT=6, SHUTDOWN=7.
REQ-018 Timer: 16-bit down-counter, loaded with N on state entry; a timed state exits in the cycle the timer reads 0, so it lasts N+1 cycles; the timer never wraps below 0.
REQ-019 OFF: amp_en=0, amp_mute_n=0; enable=1 -> POWER_UP, load T_SETTLE.
REQ-020 POWER_UP: amp_en=1, mute; timer 0 -> CONFIG.
REQ-021 CONFIG lasts exactly 1 cycle with send_cfg=1 -> WAIT_CFG, load T_CFG_TO; send_cfg SHALL be 0 in every other state.
REQ-022 WAIT_CFG: cfg_done=1 -> UNMUTE_DLY, load T_MUTE; timer 0 without cfg_done -> FAULT; if cfg_done and timer 0 occur in the same cycle, cfg_done wins.
REQ-023 UNMUTE_DLY: timer 0 -> RUN; amp_mute_n goes 1 in the first RUN cycle.
REQ-024 RUN: amp_en=1, amp_mute_n=1; remains until enable=0 or fault_sync=1.
REQ-025 fault_sync=1 in WAIT_CFG, UNMUTE_DLY or RUN -> FAULT; fault_sync is ignored in POWER_UP and CONFIG.
REQ-026 FAULT: amp_en=0, amp_mute_n=0, fault=1; exit per REQ-032/033.
REQ-027 enable=0 in POWER_UP..RUN -> SHUTDOWN, load T_MUTE; enable=0 takes priority over fault and timer events in the same cycle.
REQ-028 SHUTDOWN: amp_mute_n=0, amp_en=1; timer 0 -> OFF; enable returning to 1 does not abort SHUTDOWN.
REQ-029 enable=0 in FAULT -> OFF directly.
REQ-030 A 2-bit retry_cnt SHALL clear in OFF only and saturate at MAX_RETRY.
REQ-031 All outputs SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-032 resetb=0 SHALL force state OFF, timer=0, retry_cnt=0, synchronizer flops=0, amp_en=0, send_cfg=0, amp_mute_n=0, fault=0, seq_state=0, on the next clk edge and from any state, including mid-WAIT_CFG.

Configuration
REQ-033 Macro AMP_SEQ_RETRY_EN defined: in FAULT with retry_cnt<MAX_RETRY, wait T_OFF (timer), increment retry_cnt, then -> POWER_UP, load T_SETTLE; with retry_cnt=MAX_RETRY, stay in FAULT until enable=0.
REQ-034 Macro AMP_SEQ_RETRY_EN undefined: FAULT is latched until enable=0; retry_cnt is absent and the T_OFF/MAX_RETRY parameters are unused.

Verification (small parameters: T_SETTLE=10, T_CFG_TO=20, T_MUTE=5, T_OFF=8, MAX_RETRY=2)
REQ-035 Normal power-up: enable=1 at cycle 0, cfg_done pulsed 3 cycles after send_cfg -> amp_en=1 from cycle 1, send_cfg single pulse at cycle 12, amp_mute_n=1 and seq_state=5 after a further 6 UNMUTE_DLY cycles.
REQ-036 Config timeout: cfg_done never asserted -> FAULT after 21 WAIT_CFG cycles, amp_en=0, fault=1; same-cycle cfg_done at timer 0 instead -> UNMUTE_DLY.
REQ-037 Run fault: amp_fault_n=0 in RUN -> FAULT at cycle +3; with AMP_SEQ_RETRY_EN, two retries occur (9 cycles off each), then a permanent FAULT; without it, FAULT persists until enable=0.
REQ-038 Shutdown: enable=0 in RUN -> amp_mute_n=0 next cycle, amp_en=0 after 6 SHUTDOWN cycles, seq_state=0; enable toggled back to 1 during SHUTDOWN has no effect until OFF.
REQ-039 Reset mid-operation: resetb=0 for 1 cycle during WAIT_CFG -> all outputs at reset values next edge; a late cfg_done is ignored in OFF.
REQ-040 Fault during POWER_UP: amp_fault_n=0 -> ignored, send_cfg still issued on schedule.

Source files
------------

// File: rtl/amp_power_sequencer.sv
// -----------------------------------------------------------------------------
// amp_power_sequencer
//
// Power / configuration / mute sequencer for an audio power amplifier with an
// I2C boot program. Brings the amp up (enable, settle, configure, unmute),
// holds it in RUN, and takes it down cleanly (mute dwell before power-off).
// A fault pin from the amp, or a configuration timeout, drops the amp into
// FAULT.
//
// Build option:
//   AMP_SEQ_RETRY_EN  defined   -> FAULT power-cycles the amp automatically
//                                  (T_OFF off-time, up to MAX_RETRY attempts;
//                                  the retry count clears only in OFF).
//                     undefined -> FAULT is latched until enable drops.
//
// Ports:
//   clk          in   system clock, rising edge
//   resetb       in   synchronous active-low reset
//   enable       in   level request to run the amplifier
//   cfg_done     in   one-cycle pulse: I2C boot program has been sent
//   amp_fault_n  in   asynchronous active-low fault pin from the amp
//   amp_en       out  amp enable / power pin
//   send_cfg     out  one-cycle pulse that starts the I2C config master
//   amp_mute_n   out  active-low mute (1 = playing)
//   fault        out  high while in FAULT
//   seq_state    out  current state encoding (see table)
//
// state       | meaning
// ------------+----------------------------------------------------------
// OFF      0  | amp unpowered, waiting for enable
// POWER_UP 1  | amp powered and muted, supply settling (T_SETTLE+1 cycles)
// CONFIG   2  | single cycle, pulses send_cfg
// WAIT_CFG 3  | waiting for cfg_done, T_CFG_TO+1 cycles before timeout
// UNMUTE_DLY 4| config done, muted dwell (T_MUTE+1 cycles)
// RUN      5  | amp playing
// FAULT    6  | amp unpowered, fault flagged
// SHUTDOWN 7  | muted dwell before power-off (T_MUTE+1 cycles)
// -----------------------------------------------------------------------------
module amp_power_sequencer #(
    parameter int unsigned T_SETTLE  = 1000,
    parameter int unsigned T_CFG_TO  = 4000,
    parameter int unsigned T_MUTE    = 500,
    parameter int unsigned T_OFF     = 2000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable,
    input  logic       cfg_done,
    input  logic       amp_fault_n,
    output logic       amp_en,
    output logic       send_cfg,
    output logic       amp_mute_n,
    output logic       fault,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_POWER_UP   = 3'd1,
        S_CONFIG     = 3'd2,
        S_WAIT_CFG   = 3'd3,
        S_UNMUTE_DLY = 3'd4,
        S_RUN        = 3'd5,
        S_FAULT      = 3'd6,
        S_SHUTDOWN   = 3'd7
    } state_t;

    // Parameter sanity: timers are 16 bits, retry counter is 2 bits.
    if (T_SETTLE > 65535 || T_CFG_TO > 65535 || T_MUTE > 65535 || T_OFF > 65535) begin : g_bad_timer
        $error("amp_power_sequencer: timer parameter exceeds 16 bits");
    end
    if (MAX_RETRY > 3) begin : g_bad_retry
        $error("amp_power_sequencer: MAX_RETRY exceeds 2-bit retry counter");
    end

    state_t      state;
    state_t      state_next;
    logic [15:0] timer;
    logic [15:0] timer_load;
    logic        timer_zero;

    logic        fault_meta;
    logic        fault_meta2;
    logic        fault_sync;

    logic        amp_en_d;
    logic        send_cfg_d;
    logic        amp_mute_n_d;
    logic        fault_d;

    logic        retry_ok;

    // Two-flop synchronizer; the flops reset to 0, so fault_sync reads 1 for
    // two cycles after reset. That is harmless: it is only looked at from
    // WAIT_CFG onward, which is always many cycles away from OFF.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            fault_meta  <= 1'b0;
            fault_meta2 <= 1'b0;
        end else begin
            fault_meta  <= amp_fault_n;
            fault_meta2 <= fault_meta;
        end
    end

    assign fault_sync = ~fault_meta2;
    assign timer_zero = (timer == 16'd0);

`ifdef AMP_SEQ_RETRY_EN
    logic [1:0] retry_cnt;

    assign retry_ok = (retry_cnt < 2'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (!resetb) begin
            retry_cnt <= 2'd0;
        end else if (state == S_OFF) begin
            retry_cnt <= 2'd0;
        end else if (state == S_FAULT && state_next == S_POWER_UP) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // State register, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state      <= S_OFF;
            timer      <= 16'd0;
            amp_en     <= 1'b0;
            send_cfg   <= 1'b0;
            amp_mute_n <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= timer_load;
            end else if (!timer_zero) begin
                timer <= timer - 16'd1;
            end
            amp_en     <= amp_en_d;
            send_cfg   <= send_cfg_d;
            amp_mute_n <= amp_mute_n_d;
            fault      <= fault_d;
        end
    end

    // Next state. Dropping enable beats fault and timer events; in WAIT_CFG a
    // synchronized fault beats cfg_done, and cfg_done beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_OFF: begin
                if (enable) state_next = S_POWER_UP;
            end
            S_POWER_UP: begin
                if (!enable)         state_next = S_SHUTDOWN;
                else if (timer_zero) state_next = S_CONFIG;
            end
            S_CONFIG: begin
                if (!enable) state_next = S_SHUTDOWN;
                else         state_next = S_WAIT_CFG;
            end
            S_WAIT_CFG: begin
                if (!enable)         state_next = S_SHUTDOWN;
                else if (fault_sync) state_next = S_FAULT;
                else if (cfg_done)   state_next = S_UNMUTE_DLY;
                else if (timer_zero) state_next = S_FAULT;
            end
            S_UNMUTE_DLY: begin
                if (!enable)         state_next = S_SHUTDOWN;
                else if (fault_sync) state_next = S_FAULT;
                else if (timer_zero) state_next = S_RUN;
            end
            S_RUN: begin
                if (!enable)         state_next = S_SHUTDOWN;
                else if (fault_sync) state_next = S_FAULT;
            end
            S_FAULT: begin
                if (!enable)                     state_next = S_OFF;
                else if (timer_zero && retry_ok) state_next = S_POWER_UP;
            end
            S_SHUTDOWN: begin
                if (timer_zero) state_next = S_OFF;
            end
            default: state_next = S_OFF;
        endcase
    end

    // Outputs and timer reload are decoded from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        amp_en_d     = 1'b0;
        send_cfg_d   = 1'b0;
        amp_mute_n_d = 1'b0;
        fault_d      = 1'b0;
        timer_load   = 16'd0;
        case (state_next)
            S_POWER_UP: begin
                amp_en_d   = 1'b1;
                timer_load = 16'(T_SETTLE);
            end
            S_CONFIG: begin
                amp_en_d   = 1'b1;
                send_cfg_d = 1'b1;
            end
            S_WAIT_CFG: begin
                amp_en_d   = 1'b1;
                timer_load = 16'(T_CFG_TO);
            end
            S_UNMUTE_DLY: begin
                amp_en_d   = 1'b1;
                timer_load = 16'(T_MUTE);
            end
            S_RUN: begin
                amp_en_d     = 1'b1;
                amp_mute_n_d = 1'b1;
            end
            S_FAULT: begin
                fault_d    = 1'b1;
                timer_load = 16'(T_OFF);
            end
            S_SHUTDOWN: begin
                amp_en_d   = 1'b1;
                timer_load = 16'(T_MUTE);
            end
            default: begin
                amp_en_d = 1'b0;
            end
        endcase
    end

    assign seq_state = state;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// Bench for amp_power_sequencer. Each scenario builds a cycle timeline
// (expected state per cycle plus the inputs driven in that cycle) from the
// documented durations, plays the inputs, records the outputs each cycle and
// compares them against the outputs implied by the expected state.
module tb_amp_power_sequencer;

    localparam int T_SETTLE  = 10;
    localparam int T_CFG_TO  = 20;
    localparam int T_MUTE    = 5;
    localparam int T_OFF     = 8;
    localparam int MAX_RETRY = 2;

    localparam int OFF = 0, PU = 1, CFG = 2, WAIT = 3, UNM = 4, RUN = 5, FLT = 6, SHUT = 7;

`ifdef AMP_SEQ_RETRY_EN
    localparam int RETRIES = MAX_RETRY;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       enable = 1'b0;
    logic       cfg_done = 1'b0;
    logic       amp_fault_n = 1'b1;
    logic       amp_en;
    logic       send_cfg;
    logic       amp_mute_n;
    logic       fault;
    logic [2:0] seq_state;

    int total = 0;
    int bad   = 0;

    int         exp_st[$];
    bit         s_en[$];
    bit         s_cfg[$];
    bit         s_flt[$];
    bit         s_rst[$];
    logic [6:0] obs[$];

    always #5 clk = ~clk;

    amp_power_sequencer #(
        .T_SETTLE (T_SETTLE),
        .T_CFG_TO (T_CFG_TO),
        .T_MUTE   (T_MUTE),
        .T_OFF    (T_OFF),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (enable),
        .cfg_done   (cfg_done),
        .amp_fault_n(amp_fault_n),
        .amp_en     (amp_en),
        .send_cfg   (send_cfg),
        .amp_mute_n (amp_mute_n),
        .fault      (fault),
        .seq_state  (seq_state)
    );

    // {amp_en, send_cfg, amp_mute_n, fault, seq_state} expected in a state.
    function automatic logic [6:0] exp_vec(int st);
        logic en, snd, mn, f;
        logic [2:0] code;
        en = 1'b0; snd = 1'b0; mn = 1'b0; f = 1'b0;
        code = 3'(st);
        case (st)
            PU, WAIT, UNM, SHUT: en = 1'b1;
            CFG: begin en = 1'b1; snd = 1'b1; end
            RUN: begin en = 1'b1; mn = 1'b1; end
            FLT: f = 1'b1;
            default: en = 1'b0;
        endcase
        return {en, snd, mn, f, code};
    endfunction

    task automatic clear_q();
        exp_st.delete(); s_en.delete(); s_cfg.delete();
        s_flt.delete(); s_rst.delete(); obs.delete();
    endtask

    task automatic push_cyc(int st, bit en, bit cfg, bit flt, bit rst, int n);
        for (int i = 0; i < n; i++) begin
            exp_st.push_back(st);
            s_en.push_back(en);
            s_cfg.push_back(cfg);
            s_flt.push_back(flt);
            s_rst.push_back(rst);
        end
    endtask

    // From OFF: enable rises in cycle 0, cfg_done arrives d cycles after
    // send_cfg (d = T_CFG_TO+1 lands on the timeout cycle itself).
    task automatic add_boot(int d);
        push_cyc(OFF,  1, 0, 1, 1, 1);
        push_cyc(PU,   1, 0, 1, 1, T_SETTLE + 1);
        push_cyc(CFG,  1, 0, 1, 1, 1);
        push_cyc(WAIT, 1, 0, 1, 1, d - 1);
        push_cyc(WAIT, 1, 1, 1, 1, 1);
        push_cyc(UNM,  1, 0, 1, 1, T_MUTE + 1);
    endtask

    // r RUN cycles, enable dropped in the last one, full shutdown to OFF.
    task automatic add_run_and_stop(int r);
        push_cyc(RUN,  1, 0, 1, 1, r - 1);
        push_cyc(RUN,  0, 0, 1, 1, 1);
        push_cyc(SHUT, 0, 0, 1, 1, T_MUTE + 1);
        push_cyc(OFF,  0, 0, 1, 1, 1);
    endtask

    // Plays the timeline: obs[i] holds the outputs in cycle i, sampled at the
    // falling edge, then the inputs for cycle i are applied.
    task automatic run_stim();
        for (int i = 0; i < exp_st.size(); i++) begin
            obs.push_back({amp_en, send_cfg, amp_mute_n, fault, seq_state});
            enable      = s_en[i];
            cfg_done    = s_cfg[i];
            amp_fault_n = s_flt[i];
            resetb      = s_rst[i];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; enable = 1'b1; cfg_done = 1'b0; amp_fault_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({amp_en, send_cfg, amp_mute_n, fault, seq_state} !== 7'd0) begin
            bad++;
            $display("FAIL reset_values got=%b exp=%b", {amp_en, send_cfg, amp_mute_n, fault, seq_state}, 7'd0);
        end
        enable = 1'b0;
        @(negedge clk);
        clear_q();
        push_cyc(OFF, 0, 0, 1, 1, 1);
        push_cyc(OFF, 0, 1, 1, 1, 1);
        push_cyc(OFF, 0, 0, 1, 1, 4);
        run_stim();
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_vec(exp_st[i])) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs[i], exp_vec(exp_st[i]));
            end
        end
    endtask

    task automatic test_power_up();
        for (int k = 0; k < 3; k++) begin
            int d, r;
            d = (k == 0) ? 3 : int'($urandom_range(1, T_CFG_TO));
            r = int'($urandom_range(1, 8));
            clear_q();
            add_boot(d);
            add_run_and_stop(r);
            run_stim();
            for (int i = 0; i < obs.size(); i++) begin
                total++;
                if (obs[i] !== exp_vec(exp_st[i])) begin
                    bad++;
                    $display("FAIL power_up d=%0d cyc=%0d got=%b exp=%b", d, i, obs[i], exp_vec(exp_st[i]));
                end
            end
        end
    endtask

    task automatic test_cfg_timeout();
        int h;
        h = int'($urandom_range(2, 10));
        clear_q();
        push_cyc(OFF,  1, 0, 1, 1, 1);
        push_cyc(PU,   1, 0, 1, 1, T_SETTLE + 1);
        push_cyc(CFG,  1, 0, 1, 1, 1);
        push_cyc(WAIT, 1, 0, 1, 1, T_CFG_TO + 1);
        for (int k = 0; k < RETRIES; k++) begin
            push_cyc(FLT,  1, 0, 1, 1, T_OFF + 1);
            push_cyc(PU,   1, 0, 1, 1, T_SETTLE + 1);
            push_cyc(CFG,  1, 0, 1, 1, 1);
            push_cyc(WAIT, 1, 0, 1, 1, T_CFG_TO + 1);
        end
        push_cyc(FLT, 1, 0, 1, 1, h - 1);
        push_cyc(FLT, 0, 0, 1, 1, 1);
        push_cyc(OFF, 0, 0, 1, 1, 2);
        // cfg_done on the last timer cycle still wins over the timeout.
        add_boot(T_CFG_TO + 1);
        add_run_and_stop(2);
        run_stim();
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_vec(exp_st[i])) begin
                bad++;
                $display("FAIL cfg_timeout cyc=%0d got=%b exp=%b", i, obs[i], exp_vec(exp_st[i]));
            end
        end
    endtask

    task automatic test_run_fault();
        for (int pass = 0; pass < 2; pass++) begin
            int j, h;
            j = int'($urandom_range(1, 6));
            h = int'($urandom_range(2, 12));
            clear_q();
            add_boot(int'($urandom_range(1, T_CFG_TO)));
            push_cyc(RUN, 1, 0, 1, 1, j);
            push_cyc(RUN, 1, 0, 0, 1, 3);
            for (int k = 0; k < RETRIES; k++) begin
                push_cyc(FLT,  1, 0, 0, 1, T_OFF + 1);
                push_cyc(PU,   1, 0, 0, 1, T_SETTLE + 1);
                push_cyc(CFG,  1, 0, 0, 1, 1);
                push_cyc(WAIT, 1, 0, 0, 1, 1);
            end
            push_cyc(FLT, 1, 0, 0, 1, h);
            push_cyc(FLT, 0, 0, 0, 1, 1);
            push_cyc(OFF, 0, 0, 1, 1, 3);
            run_stim();
            for (int i = 0; i < obs.size(); i++) begin
                total++;
                if (obs[i] !== exp_vec(exp_st[i])) begin
                    bad++;
                    $display("FAIL run_fault pass=%0d cyc=%0d got=%b exp=%b", pass, i, obs[i], exp_vec(exp_st[i]));
                end
            end
        end
    endtask

    task automatic test_shutdown();
        int t, p;
        t = int'($urandom_range(0, T_MUTE));
        p = int'($urandom_range(1, T_SETTLE + 1));
        clear_q();
        add_boot(int'($urandom_range(1, T_CFG_TO)));
        push_cyc(RUN, 1, 0, 1, 1, 3);
        push_cyc(RUN, 0, 0, 1, 1, 1);
        for (int i = 0; i <= T_MUTE; i++) push_cyc(SHUT, (i >= t), 0, 1, 1, 1);
        push_cyc(OFF,  1, 0, 1, 1, 1);
        push_cyc(PU,   1, 0, 1, 1, p - 1);
        push_cyc(PU,   0, 0, 1, 1, 1);
        push_cyc(SHUT, 0, 0, 1, 1, T_MUTE + 1);
        push_cyc(OFF,  0, 0, 1, 1, 2);
        run_stim();
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_vec(exp_st[i])) begin
                bad++;
                $display("FAIL shutdown t=%0d p=%0d cyc=%0d got=%b exp=%b", t, p, i, obs[i], exp_vec(exp_st[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        w = int'($urandom_range(1, T_CFG_TO));
        clear_q();
        push_cyc(OFF,  1, 0, 1, 1, 1);
        push_cyc(PU,   1, 0, 1, 1, T_SETTLE + 1);
        push_cyc(CFG,  1, 0, 1, 1, 1);
        push_cyc(WAIT, 1, 0, 1, 1, w - 1);
        push_cyc(WAIT, 1, 0, 1, 0, 1);
        push_cyc(OFF,  0, 1, 1, 1, 1);
        push_cyc(OFF,  0, 0, 1, 1, 2);
        // Reset out of RUN with enable held: restarts, enable drops in CONFIG.
        add_boot(int'($urandom_range(1, T_CFG_TO)));
        push_cyc(RUN,  1, 0, 1, 0, 1);
        push_cyc(OFF,  1, 0, 1, 1, 1);
        push_cyc(PU,   1, 0, 1, 1, T_SETTLE + 1);
        push_cyc(CFG,  0, 0, 1, 1, 1);
        push_cyc(SHUT, 0, 0, 1, 1, T_MUTE + 1);
        push_cyc(OFF,  0, 0, 1, 1, 2);
        run_stim();
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_vec(exp_st[i])) begin
                bad++;
                $display("FAIL reset_mid w=%0d cyc=%0d got=%b exp=%b", w, i, obs[i], exp_vec(exp_st[i]));
            end
        end
    endtask

    task automatic test_fault_power_up();
        int l;
        l = int'($urandom_range(1, T_SETTLE));
        clear_q();
        add_boot(3);
        for (int i = 1; i <= l; i++) s_flt[i] = 1'b0;
        add_run_and_stop(2);
        run_stim();
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_vec(exp_st[i])) begin
                bad++;
                $display("FAIL fault_power_up l=%0d cyc=%0d got=%b exp=%b", l, i, obs[i], exp_vec(exp_st[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int k = 0; k < 4; k++) begin
            add_boot(int'($urandom_range(1, T_CFG_TO + 1)));
            add_run_and_stop(int'($urandom_range(1, 6)));
        end
        run_stim();
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i] !== exp_vec(exp_st[i])) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, obs[i], exp_vec(exp_st[i]));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_power_up();
        test_cfg_timeout();
        test_run_fault();
        test_shutdown();
        test_reset_mid();
        test_fault_power_up();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
